// File: rtl/bitfusion_pkg.sv
// Shared widths, collector state encoding and sign-extension helper for the fusion-unit column logic.
package bitfusion_pkg;

    localparam int PSUM_W_DEF = 19;
    localparam int ACC_W_DEF  = 32;
    localparam int SEXT_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Sign-extends the low w bits of v to SEXT_MAX_W bits; callers truncate to their width.
    function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v, input int w);
        logic signed [SEXT_MAX_W-1:0] t;
        t = $signed(v << (SEXT_MAX_W - w));
        return t >>> (SEXT_MAX_W - w);
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a pop in the same cycle frees room for a push when full.
module psum_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Accumulates acc_len column partial sums per output word and queues num_out words per job.
// Define PSUM_COLLECTOR_RELU_EN to clamp negative words to zero at the FIFO push.
module psum_collector
    import bitfusion_pkg::*;
#(
    parameter int PSUM_W     = PSUM_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  acc_len,
    input  logic [CNT_W-1:0]  num_out,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy,
    output logic              done,
    output logic              ovf_err
);
    state_e            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  acc_len_q;
    logic [CNT_W-1:0]  num_out_q;
    logic              done_q;
    logic              ovf_q;

    logic              accept;
    logic              last_beat;
    logic [ACC_W-1:0]  push_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    // start takes priority over a coincident beat, which is dropped with the aborted job.
    assign accept    = (state_q == ST_RUN) && psum_valid && !start;
    assign last_beat = accept && (beat_cnt_q == acc_len_q - CNT_W'(1));
    assign acc_d     = acc_q + ACC_W'(sext(SEXT_MAX_W'(psum_in), PSUM_W));
    assign fifo_pop  = !fifo_empty && out_ready;

`ifdef PSUM_COLLECTOR_RELU_EN
    assign push_word = acc_d[ACC_W-1] ? '0 : acc_d;
`else
    assign push_word = acc_d;
`endif

    psum_fifo #(
        .W     (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (last_beat),
        .din   (push_word),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            beat_cnt_q <= '0;
            word_cnt_q <= '0;
            acc_len_q  <= '0;
            num_out_q  <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                acc_len_q  <= (acc_len == '0) ? CNT_W'(1) : acc_len;
                num_out_q  <= num_out;
                acc_q      <= '0;
                beat_cnt_q <= '0;
                word_cnt_q <= '0;
                ovf_q      <= 1'b0;
                state_q    <= (num_out == '0) ? ST_DRAIN : ST_RUN;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (last_beat) begin
                            acc_q      <= '0;
                            beat_cnt_q <= '0;
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                            if (fifo_full && !fifo_pop) begin
                                ovf_q <= 1'b1;
                            end
                            if (word_cnt_q == num_out_q - CNT_W'(1)) begin
                                state_q <= ST_DRAIN;
                            end
                        end else if (accept) begin
                            acc_q      <= acc_d;
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (fifo_empty) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: expected words go into a queue, a negedge monitor checks every handshake.
module tb_psum_collector;

  localparam int PSUM_W = 19;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  acc_len = '0;
  logic [CNT_W-1:0]  num_out = '0;
  logic              psum_valid = 1'b0;
  logic [PSUM_W-1:0] psum_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              done;
  logic              ovf_err;

  int total = 0;
  int bad   = 0;
  logic [ACC_W-1:0] exp_q[$];

  psum_collector #(
    .PSUM_W     (PSUM_W),
    .ACC_W      (ACC_W),
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .acc_len    (acc_len),
    .num_out    (num_out),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .ovf_err    (ovf_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0d (0x%0h) req=%0d (0x%0h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_data, 32'hDEAD_BEEF);
      end else begin
        check("out_word", out_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input int n);
    start   = 1'b1;
    acc_len = CNT_W'(len);
    num_out = CNT_W'(n);
    tick();
    start   = 1'b0;
  endtask

  task automatic beat(input int v);
    psum_valid = 1'b1;
    psum_in    = PSUM_W'(v);
    tick();
    psum_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    check("done_seen", {31'd0, done}, 1);
    check("busy_at_done", {31'd0, busy}, 0);
    tick();
    check("done_one_cycle", {31'd0, done}, 0);
  endtask

  initial begin
    int v;
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_ovf", {31'd0, ovf_err}, 0);
    rst_n = 1'b1;
    tick();

    // ignored psum in IDLE
    beat(55);
    check("idle_ignores_psum", {31'd0, out_valid}, 0);

    // basic 4-beat word, one-cycle latency
    out_ready = 1'b1;
    do_start(4, 1);
    check("busy_after_start", {31'd0, busy}, 1);
    exp_q.push_back(32'd114);
    beat(10); beat(-3); beat(7);
    check("no_word_early", {31'd0, out_valid}, 0);
    beat(100);
    check("latency_valid", {31'd0, out_valid}, 1);
    wait_done(20);

    // acc_len 0 treated as 1
    do_start(0, 2);
`ifdef PSUM_COLLECTOR_RELU_EN
    exp_q.push_back(32'd0);
`else
    exp_q.push_back(-32'sd5);
`endif
    exp_q.push_back(32'd6);
    beat(-5); beat(6);
    wait_done(20);

    // overflow: six words into a 4-deep FIFO with no drain
    out_ready = 1'b0;
    do_start(1, 6);
    for (int i = 1; i <= 4; i++) exp_q.push_back(ACC_W'(i));
    for (int i = 1; i <= 6; i++) beat(i);
    check("ovf_set", {31'd0, ovf_err}, 1);
    check("ovf_busy_drain", {31'd0, busy}, 1);
    tick(); tick();
    check("head_stable", out_data, 1);
    out_ready = 1'b1;
    wait_done(30);
    check("ovf_sticky", {31'd0, ovf_err}, 1);

    // full FIFO with simultaneous pop and push
    out_ready = 1'b0;
    do_start(1, 5);
    check("ovf_cleared_by_start", {31'd0, ovf_err}, 0);
    for (int i = 1; i <= 5; i++) exp_q.push_back(ACC_W'(10 * i));
    for (int i = 1; i <= 4; i++) beat(10 * i);
    out_ready = 1'b1;
    beat(50);
    wait_done(30);
    check("no_drop_ovf", {31'd0, ovf_err}, 0);

    // sign extension at the extremes
    do_start(3, 1);
    exp_q.push_back(32'd0);
    beat(262143); beat(-262144); beat(1);
    wait_done(20);

    // restart keeps FIFO contents, then async reset mid-beat
    out_ready = 1'b0;
    do_start(1, 2);
    beat(7); beat(8);
    do_start(4, 1);
    check("restart_keeps_fifo", {31'd0, out_valid}, 1);
    check("restart_busy", {31'd0, busy}, 1);
    beat(2);
    psum_valid = 1'b1;
    psum_in    = PSUM_W'(2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_out_valid", {31'd0, out_valid}, 0);
    check("async_out_data", out_data, 0);
    check("async_busy", {31'd0, busy}, 0);
    check("async_done", {31'd0, done}, 0);
    check("async_ovf", {31'd0, ovf_err}, 0);
    psum_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    do_start(4, 1);
    exp_q.push_back(32'd8);
    for (int i = 0; i < 4; i++) beat(2);
    wait_done(20);

    v = exp_q.size();
    check("queue_drained", ACC_W'(v), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
